// File: rtl/shapool_pkg.sv
// Shared types and nonce-word packing for the shapool result path and the job loader.
package shapool_pkg;

    localparam int SHAPOOL_NONCE_W  = 32;
    localparam int SHAPOOL_PIPE_LAG = 2;
    // Track index shares the low nonce byte with the counter's top bits, so it never exceeds 8 bits.
    localparam int SHAPOOL_TRACK_W  = 8;

    typedef struct packed {
        logic [SHAPOOL_NONCE_W-1:0] nonce_word;
        logic [SHAPOOL_TRACK_W-1:0] track;
    } shapool_result_t;

    // Message byte order: {c[7:0], c[15:8], c[23:16], track[track_w-1:0], c[31-track_w:24]}.
    function automatic logic [31:0] pack_nonce_word(input logic [31:0] c,
                                                    input logic [7:0]  track,
                                                    input int unsigned track_w);
        logic [7:0] lo_mask;
        logic [7:0] low8;
        lo_mask = 8'hFF >> track_w;
        low8    = ((track << (8 - track_w)) & ~lo_mask) | (c[31:24] & lo_mask);
        return {c[7:0], c[15:8], c[23:16], low8};
    endfunction

endpackage

// File: rtl/shapool_result_fifo.sv
// Result FIFO with a registered head entry; full/empty come from an extra pointer wrap bit.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             full,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic             pop, empty_nx;
    logic [WIDTH-1:0] head_nx;

    assign pop       = rd_valid & rd_ready;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_ptr_nx = wr_ptr + (AW+1)'(wr_en);
    assign rd_ptr_nx = rd_ptr + (AW+1)'(pop);
    assign empty_nx  = (wr_ptr_nx == rd_ptr_nx);

    // A write landing on the next head slot means it is the only entry left: bypass it.
    assign head_nx = (wr_en && (wr_ptr[AW-1:0] == rd_ptr_nx[AW-1:0])) ? wr_data
                                                                      : mem[rd_ptr_nx[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            rd_valid <= ~empty_nx;
            if (!empty_nx) rd_data <= head_nx;
        end
    end

endmodule

// File: rtl/shapool_result.sv
// Captures hashing-pool successes, rebuilds the golden nonce word and queues it for readout.
// Build option: SHAPOOL_RESULT_HALT_EN adds a sticky halt request on the first accepted capture.
module shapool_result
    import shapool_pkg::*;
#(
    parameter int POOL_SIZE      = 1,
    parameter int POOL_SIZE_LOG2 = 0,
    parameter int NONCE_WIDTH    = 32 - POOL_SIZE_LOG2,
    parameter int DEPTH          = 4,
    parameter int PIPE_LAG       = SHAPOOL_PIPE_LAG,
    localparam int TRACK_W       = (POOL_SIZE_LOG2 > 0) ? POOL_SIZE_LOG2 : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   success,
    input  logic [POOL_SIZE-1:0]   match_flags,
    input  logic [NONCE_WIDTH-1:0] nonce,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_nonce,
    output logic [TRACK_W-1:0]     out_track,
    output logic [7:0]             overflow_cnt,
    output logic                   halt
);

    logic                   capture, pop, accept, full;
    logic [TRACK_W-1:0]     track_idx;
    logic [NONCE_WIDTH-1:0] cnt;
    shapool_result_t        wr_entry, head;
    logic                   unused_track;

    // Lowest set index wins; scanning downward lets the last hit overwrite.
    always_comb begin
        track_idx = '0;
        for (int i = POOL_SIZE - 1; i >= 0; i--) begin
            if (match_flags[i]) track_idx = TRACK_W'(i);
        end
    end

    assign capture = success & ~clear;
    assign pop     = out_valid & out_ready;
    assign accept  = capture & (~full | pop);
    assign cnt     = nonce - NONCE_WIDTH'(PIPE_LAG);

    assign wr_entry.nonce_word = pack_nonce_word(32'(cnt), 8'(track_idx), POOL_SIZE_LOG2);
    assign wr_entry.track      = 8'(track_idx);

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(shapool_result_t))
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .wr_en    (accept),
        .wr_data  (wr_entry),
        .rd_ready (out_ready),
        .full     (full),
        .rd_valid (out_valid),
        .rd_data  (head)
    );

    assign out_nonce    = head.nonce_word;
    assign out_track    = head.track[TRACK_W-1:0];
    assign unused_track = ^head.track;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_cnt <= '0;
        end else if (clear) begin
            overflow_cnt <= '0;
        end else if (capture && !accept && overflow_cnt != 8'hFF) begin
            overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

`ifdef SHAPOOL_RESULT_HALT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    halt <= 1'b0;
        else if (clear)  halt <= 1'b0;
        else if (accept) halt <= 1'b1;
    end
`else
    assign halt = 1'b0;
`endif

endmodule
